// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: access-type encodings, FSM states and access-size helper.
package data_mem_responder_pkg;
  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  function automatic logic [2:0] size_of(input logic [2:0] rw);
    return rw[1:0] == 2'b00 ? 3'd1 : rw[1:0] == 2'b01 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables and shifted store data for a word pair, plus load extract/extend.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [2:0]  rw_type,
  input  logic [31:0] dat,
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] load_data
);
  logic [3:0]  szm;
  logic [31:0] ld;
  always_comb begin
    szm = size == 3'd1 ? 4'b0001 : size == 3'd2 ? 4'b0011 : 4'b1111;
    {be1, be0} = {4'b0, szm} << off;
    {wdata1, wdata0} = {32'b0, dat} << {off, 3'b000};
    ld = 32'({word1, word0} >> {off, 3'b000});
    load_data = rw_type == RW_B  ? {{24{ld[7]}}, ld[7:0]} :
                rw_type == RW_H  ? {{16{ld[15]}}, ld[15:0]} :
                rw_type == RW_BU ? {24'b0, ld[7:0]} :
                rw_type == RW_HU ? {16'b0, ld[15:0]} : ld;
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder with byte-lane stores, extended loads and split misaligned accesses.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          ADDR_W    = 9,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [2:0]  rw_type,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ready,
  output logic        err
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [31:0] mem [DEPTH];
  state_t st, nst;
  logic [1:0]  off_q;
  logic [2:0]  size_q, rw_q;
  logic        we_q, err_q, strad_q;
  logic [31:0] dat_q, w0;
  logic [ADDR_W-1:0] idx0_q, idx1, idx_in;
  logic [31:0] rel, word0, wd0, wd1, wd, ld;
  logic [3:0]  be0, be1, wbe;
  logic [2:0]  sz_in;
  logic        strad_in, bad_in, wr;
  always_comb begin
    rel = addr - BASE_ADDR;
    idx_in = rel[ADDR_W+1:2];
    sz_in = size_of(rw_type);
    strad_in = ({2'b0, addr[1:0]} + {1'b0, sz_in}) > 4'd4;
    // Rejection is decided here, before any storage write can happen
    bad_in = !(rw_type inside {RW_B, RW_H, RW_W, RW_BU, RW_HU}) || (wr_en && rw_type[2]) ||
             rel >= 32'(4 * DEPTH) || (strad_in && &idx_in);
    idx1 = idx0_q + 1'b1;
    word0 = st == ACC0 ? mem[idx0_q] : w0;
    wr = we_q && !err_q && (st == ACC0 || st == ACC1);
    wbe = st == ACC1 ? be1 : be0;
    wd = st == ACC1 ? wd1 : wd0;
  end
  mem_lane_align u_align (
    .off(off_q), .size(size_q), .rw_type(rw_q), .dat(dat_q),
    .word0(word0), .word1(mem[idx1]),
    .be0(be0), .be1(be1), .wdata0(wd0), .wdata1(wd1), .load_data(ld)
  );
  always_comb begin
    nst = st;
    ready = st == RESP;
    err = ready && err_q;
    case (st)
      IDLE: nst = req ? ACC0 : IDLE;
      ACC0: nst = strad_q && !err_q ? ACC1 : RESP;
      ACC1: nst = RESP;
      default: nst = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      off_q <= '0;
      size_q <= '0;
      rw_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      strad_q <= 1'b0;
      dat_q <= '0;
      idx0_q <= '0;
      w0 <= '0;
      dat_o <= '0;
    end else begin
      st <= nst;
      if (st == IDLE && req) begin
        off_q <= addr[1:0];
        size_q <= sz_in;
        rw_q <= rw_type;
        we_q <= wr_en;
        err_q <= bad_in;
        strad_q <= strad_in;
        dat_q <= dat_i;
        idx0_q <= idx_in;
      end
      if (st == ACC0) w0 <= mem[idx0_q];
      if (nst == RESP) dat_o <= we_q || err_q ? 32'b0 : ld;
    end
  always_ff @(posedge clk)
    if (wr)
      for (int i = 0; i < 4; i++)
        if (wbe[i]) mem[st == ACC1 ? idx1 : idx0_q][8*i +: 8] <= wd[8*i +: 8];
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory interface: accepts load/store requests (address, rw_type, write data) from the CPU and returns read data with a completion pulse.
- Byte-lane store, sign/zero-extended load, little-endian.
- Misaligned accesses that cross a word boundary are split into two internal word accesses by a small FSM.
- Sits beside the instruction ROM, between the CPU data port and a word-organised storage array.

Parameters:
- ADDR_W, 9, word-address width; storage depth is 2**ADDR_W 32-bit words (2 KB default).
- BASE_ADDR, 32'h0000_0000, byte address of word 0. The in-range window is BASE_ADDR to BASE_ADDR + 4*2**ADDR_W - 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  request valid; sampled only in IDLE.
- wr_en  in  1  1 = store, 0 = load.
- addr  in  32  byte address.
- rw_type  in  3  access type: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- dat_i  in  32  store data, right-aligned (low bits used).
- dat_o  out  32  load result, extended to 32 bits.
- ready  out  1  one-cycle completion pulse.
- err  out  1  qualifies ready; access rejected.

Behaviour:
- Reset: FSM returns to IDLE, and all request registers clear.
  - Outputs clear: dat_o=0, ready=0, err=0.
  - Storage contents are not reset (undefined until written).
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE with req=1: latch addr, wr_en, rw_type, dat_i; compute the following, then go to ACC0.
  - off = addr[1:0].
  - size = 1, 2 or 4 bytes.
  - straddle = off+size > 4.
  - idx0 = (addr-BASE_ADDR)>>2 and idx1 = idx0+1.
  - Error checks, one of which sets the latched err flag:
    - illegal rw_type (011, 110, 111);
    - store with rw_type 100/101;
    - addr outside the window;
    - straddle with idx1 beyond the last word (no wrap-around).
- IDLE with req=0: stay in IDLE.
- ACC0:
  - If err: no storage access, go to RESP.
  - Store: write the byte lanes of idx0 covered by the access. The shifted data is dat_i << 8*off, with byte enables for lanes off..min(off+size,4)-1.
  - Load: capture word idx0.
  - Next state: ACC1 if straddle, else RESP.
- ACC1:
  - Store: write the remaining low lanes of idx1 (lanes 0..off+size-5) with the upper bytes of the data.
  - Load: capture word idx1.
  - Next state: RESP.
- RESP:
  - ready=1 for exactly one cycle, with err valid in the same cycle; then go to IDLE.
  - Load assembly: the 64-bit pair {word1, word0} >> 8*off, truncated to size.
    - rw_type 000/001 sign-extend; 100/101 zero-extend; 010 passes through.
  - Stores: dat_o=0.
  - Errors: dat_o=0.
- dat_o holds its value until the next RESP; it is only meaningful while ready=1.
- Latency, counted as cycles from the accepting edge to ready high:
  - aligned or non-straddling access: 2;
  - straddling access: 3;
  - error: 2.
- Throughput: inputs are ignored outside IDLE. The earliest next accept is the cycle after ready. The CPU holds req until it sees ready, and drops it or presents the next request.
- A store of a straddling access is never partially committed when err is set; the error check happens before any write.
- Reset asserted mid-operation: abort immediately with no ready pulse. A write already committed in ACC0 remains in storage.
- Back-to-back request to the same word: the second access observes the first's write, because the write commits before RESP.

Decomposition:
- Shared package holds:
  - rw_type encodings RW_B=3'b000, RW_H=3'b001, RW_W=3'b010, RW_BU=3'b100, RW_HU=3'b101;
  - the FSM state enum;
  - a size-from-rw_type function.
- One sub-module, mem_lane_align (combinational): given off, size and data, produces byte enables and shifted store data for both words. It also performs the load extract/extend.
- Storage is a plain byte-enabled word array inside the top module.

Test Plan:
- Aligned word: sw 32'hDEADBEEF @0x10, then lw @0x10 -> ready 2 cycles after accept each time, dat_o=32'hDEADBEEF, err=0.
- Byte extension: sb 8'h80 @0x21, then lb @0x21 -> dat_o=32'hFFFF_FF80; lbu @0x21 -> 32'h0000_0080. Other lanes of word 0x20 are unchanged.
- Straddling word: sw 32'h11223344 @0x13 -> 3-cycle latency. Then lw @0x10 gives 0x44xxxxxx in the top byte, lw @0x14 gives xx112233 in the low three bytes, and lw @0x13 returns 32'h11223344.
- Straddling half: sh 16'hA55A @0x17, then lh @0x17 -> dat_o=32'hFFFF_A55A; lhu -> 32'h0000_A55A.
- Errors, each -> ready with err=1, dat_o=0, storage unchanged:
  - rw_type 3'b011;
  - sb @BASE_ADDR+0x800 (out of range);
  - sw @0x7FE (straddles past the last word);
  - sh with rw_type 101.
- Reset mid-straddle: assert rst_n=0 during ACC1 of a straddling lw -> no ready pulse; after release, FSM is in IDLE and dat_o=0; a new lw completes normally.
